// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared encodings for the instruction decoder and pipeline interlock controller.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_NOP   = 6'b111111;

  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic            is_r_type;
    logic            is_i_type;
    logic            is_j_type;
    logic            wb_from_mem;
    logic            reg_we;
    logic            mem_we;
    logic [1:0]      pc_sel;
    logic [FN_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Instruction-side inputs and datapath control strobes of the pipeline controller.
interface pipe_ctrl_unit_if;
  logic       instr_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       hz_rs;
  logic       hz_rt;
  logic       is_r_type;
  logic       is_i_type;
  logic       is_j_type;
  logic       wb_from_mem;
  logic       reg_we;
  logic       mem_we;
  logic       pc_load;
  logic [1:0] pc_sel;
  logic [5:0] alu_op;
  logic       bubble;
  logic       illegal;

  modport master (
    output instr_valid, opcode, funct, alu_zero, hz_rs, hz_rt,
    input  is_r_type, is_i_type, is_j_type, wb_from_mem, reg_we, mem_we,
    input  pc_load, pc_sel, alu_op, bubble, illegal
  );

  modport slave (
    input  instr_valid, opcode, funct, alu_zero, hz_rs, hz_rt,
    output is_r_type, is_i_type, is_j_type, wb_from_mem, reg_we, mem_we,
    output pc_load, pc_sel, alu_op, bubble, illegal
  );
endinterface

// File: rtl/pipe_ctrl_unit_instr_decoder.sv
// Combinational opcode/funct decode into datapath strobes and operand-use flags.
module instr_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter bit EN_BNE   = 1'b1,
  parameter bit EN_LOGIC = 1'b1
) (
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  input  logic            alu_zero,
  output ctrl_t           ctrl,
  output logic            illegal,
  output logic            uses_rs,
  output logic            uses_rt,
  output logic            is_branch,
  output logic            is_jump
);

  always_comb begin
    ctrl      = '0;
    illegal   = 1'b0;
    uses_rs   = 1'b1;
    uses_rt   = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        if ((funct == FN_ADD) || (funct == FN_SUB) ||
            (EN_LOGIC && ((funct == FN_AND) || (funct == FN_OR) || (funct == FN_SLT)))) begin
          ctrl.is_r_type = 1'b1;
          ctrl.reg_we    = 1'b1;
          ctrl.alu_op    = funct;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ADDI: begin
        ctrl.is_i_type = 1'b1;
        ctrl.reg_we    = 1'b1;
        ctrl.alu_op    = FN_ADD;
      end
      OP_LW: begin
        ctrl.is_i_type   = 1'b1;
        ctrl.reg_we      = 1'b1;
        ctrl.wb_from_mem = 1'b1;
        ctrl.alu_op      = FN_ADD;
      end
      OP_SW: begin
        uses_rt        = 1'b1;
        ctrl.is_i_type = 1'b1;
        ctrl.mem_we    = 1'b1;
        ctrl.alu_op    = FN_ADD;
      end
      OP_BEQ, OP_BNE: begin
        if ((opcode == OP_BEQ) || EN_BNE) begin
          uses_rt        = 1'b1;
          is_branch      = 1'b1;
          ctrl.is_i_type = 1'b1;
          ctrl.alu_op    = FN_SUB;
          // beq takes on equal operands, bne on unequal
          if (alu_zero == (opcode == OP_BEQ)) ctrl.pc_sel = PC_BRANCH;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_J: begin
        uses_rs        = 1'b0;
        is_jump        = 1'b1;
        ctrl.is_j_type = 1'b1;
        ctrl.pc_sel    = PC_JUMP;
      end
      OP_NOP: uses_rs = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Decode plus RUN/STALL/FLUSH/HALT interlock FSM gating the datapath strobes.
module pipe_ctrl_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter bit          EN_BNE       = 1'b1,
  parameter bit          EN_LOGIC     = 1'b1
) (
  input logic             clk,
  input logic             rst,
  pipe_ctrl_unit_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             illegal_q;

  ctrl_t dec;
  logic  dec_illegal, uses_rs, uses_rt, is_branch, is_jump;
  logic  hazard, transfer;

  instr_decoder #(
    .EN_BNE  (EN_BNE),
    .EN_LOGIC(EN_LOGIC)
  ) u_dec (
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .alu_zero (bus.alu_zero),
    .ctrl     (dec),
    .illegal  (dec_illegal),
    .uses_rs  (uses_rs),
    .uses_rt  (uses_rt),
    .is_branch(is_branch),
    .is_jump  (is_jump)
  );

  assign hazard   = bus.instr_valid & ((bus.hz_rs & uses_rs) | (bus.hz_rt & uses_rt));
  assign transfer = is_jump | (is_branch & (dec.pc_sel == PC_BRANCH));

  // State, bubble counter and sticky illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard) begin
            if (STALL_CYCLES > 1) begin
              state <= ST_STALL;
              cnt   <= CNT_W'(STALL_CYCLES - 1);
            end
          end else if (bus.instr_valid && dec_illegal) begin
            state     <= ST_HALT;
            illegal_q <= 1'b1;
          end else if (bus.instr_valid && transfer && (FLUSH_CYCLES != 0)) begin
            state <= ST_FLUSH;
            cnt   <= CNT_W'(FLUSH_CYCLES);
          end
        end
        ST_STALL, ST_FLUSH: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state <= ST_RUN;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RUN;
      endcase
    end
  end

  // Output gating; reset forces the sequential-fetch pattern immediately
  always_comb begin
    bus.is_r_type   = 1'b0;
    bus.is_i_type   = 1'b0;
    bus.is_j_type   = 1'b0;
    bus.wb_from_mem = 1'b0;
    bus.reg_we      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_sel      = PC_SEQ;
    bus.alu_op      = '0;
    bus.bubble      = 1'b0;
    bus.illegal     = illegal_q;
    if (rst) begin
      bus.pc_load = 1'b1;
      bus.illegal = 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard) begin
            bus.bubble = 1'b1;
          end else if (bus.instr_valid && !dec_illegal) begin
            bus.is_r_type   = dec.is_r_type;
            bus.is_i_type   = dec.is_i_type;
            bus.is_j_type   = dec.is_j_type;
            bus.wb_from_mem = dec.wb_from_mem;
            bus.reg_we      = dec.reg_we;
            bus.mem_we      = dec.mem_we;
            bus.pc_sel      = dec.pc_sel;
            bus.alu_op      = dec.alu_op;
            bus.pc_load     = 1'b1;
          end
        end
        ST_FLUSH: begin
          bus.bubble  = 1'b1;
          bus.pc_load = 1'b1;
        end
        default: bus.bubble = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (full-feature and reduced-ISA instances).
module tb_pipe_ctrl_unit;
  import cpu_ctrl_pkg::*;

  logic clk;
  logic rst;
  logic rst2;
  int   n_checks;
  int   n_errors;

  pipe_ctrl_unit_if bus();
  pipe_ctrl_unit_if bus2();

  pipe_ctrl_unit #(
    .STALL_CYCLES(3), .FLUSH_CYCLES(2), .EN_BNE(1'b1), .EN_LOGIC(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  pipe_ctrl_unit #(
    .STALL_CYCLES(3), .FLUSH_CYCLES(2), .EN_BNE(1'b0), .EN_LOGIC(1'b0)
  ) dut_nb (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  // {r,i,j,wb_mem,reg_we,mem_we,pc_load,pc_sel,alu_op,bubble,illegal}
  logic [16:0] obs, obs2;
  assign obs  = {bus.is_r_type, bus.is_i_type, bus.is_j_type, bus.wb_from_mem, bus.reg_we,
                 bus.mem_we, bus.pc_load, bus.pc_sel, bus.alu_op, bus.bubble, bus.illegal};
  assign obs2 = {bus2.is_r_type, bus2.is_i_type, bus2.is_j_type, bus2.wb_from_mem, bus2.reg_we,
                 bus2.mem_we, bus2.pc_load, bus2.pc_sel, bus2.alu_op, bus2.bubble, bus2.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ex(input logic r, i, j, w, rw, mw, pl,
                                     input logic [1:0] sel, input logic [5:0] alu,
                                     input logic b, il);
    return {r, i, j, w, rw, mw, pl, sel, alu, b, il};
  endfunction

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rs, input logic rt);
    bus.instr_valid = v;
    bus.opcode      = op;
    bus.funct       = fn;
    bus.alu_zero    = z;
    bus.hz_rs       = rs;
    bus.hz_rt       = rt;
  endtask

  task automatic drive2(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic z);
    bus2.instr_valid = v;
    bus2.opcode      = op;
    bus2.funct       = fn;
    bus2.alu_zero    = z;
    bus2.hz_rs       = 1'b0;
    bus2.hz_rt       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] e_rst, e_zero, e_bub, e_flush, e_halt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    e_rst   = ex(0,0,0,0,0,0,1,PC_SEQ,6'd0,0,0);
    e_zero  = ex(0,0,0,0,0,0,0,PC_SEQ,6'd0,0,0);
    e_bub   = ex(0,0,0,0,0,0,0,PC_SEQ,6'd0,1,0);
    e_flush = ex(0,0,0,0,0,0,1,PC_SEQ,6'd0,1,0);
    e_halt  = ex(0,0,0,0,0,0,0,PC_SEQ,6'd0,1,1);

    rst  = 1'b1;
    rst2 = 1'b1;
    drive(0, OP_NOP, 6'd0, 0, 0, 0);
    drive2(0, OP_NOP, 6'd0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", obs, e_rst);
    chk("reset2", obs2, e_rst);
    step();
    rst = 1'b0;

    // Plain decode of R/I-type instructions
    drive(1, OP_RTYPE, FN_ADD, 0, 0, 0); @(negedge clk);
    chk("add", obs, ex(1,0,0,0,1,0,1,PC_SEQ,FN_ADD,0,0)); step();
    drive(1, OP_RTYPE, FN_SUB, 0, 0, 0); @(negedge clk);
    chk("sub", obs, ex(1,0,0,0,1,0,1,PC_SEQ,FN_SUB,0,0)); step();
    drive(1, OP_RTYPE, FN_AND, 0, 0, 0); @(negedge clk);
    chk("and", obs, ex(1,0,0,0,1,0,1,PC_SEQ,FN_AND,0,0)); step();
    drive(1, OP_LW, 6'd0, 0, 0, 0); @(negedge clk);
    chk("lw", obs, ex(0,1,0,1,1,0,1,PC_SEQ,FN_ADD,0,0)); step();
    drive(1, OP_ADDI, 6'd0, 0, 0, 0); @(negedge clk);
    chk("addi", obs, ex(0,1,0,0,1,0,1,PC_SEQ,FN_ADD,0,0)); step();
    drive(1, OP_NOP, 6'd0, 0, 1, 1); @(negedge clk);
    chk("nop", obs, e_rst); step();

    // sw with rt hazard: three bubbles then the store
    drive(1, OP_SW, 6'd0, 0, 0, 1); @(negedge clk);
    chk("sw_hz", obs, e_bub); step();
    drive(1, OP_SW, 6'd0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("sw_stall", obs, e_bub); step();
    end
    @(negedge clk);
    chk("sw_go", obs, ex(0,1,0,0,0,1,1,PC_SEQ,FN_ADD,0,0)); step();

    // Taken beq flushes two cycles; untaken bne does not
    drive(1, OP_BEQ, 6'd0, 1, 0, 0); @(negedge clk);
    chk("beq_taken", obs, ex(0,1,0,0,0,0,1,PC_BRANCH,FN_SUB,0,0)); step();
    drive(0, OP_NOP, 6'd0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("beq_flush", obs, e_flush); step();
    end
    @(negedge clk); chk("beq_done", obs, e_zero); step();
    drive(1, OP_BNE, 6'd0, 1, 0, 0); @(negedge clk);
    chk("bne_untaken", obs, ex(0,1,0,0,0,0,1,PC_SEQ,FN_SUB,0,0)); step();
    drive(0, OP_NOP, 6'd0, 0, 0, 0); @(negedge clk);
    chk("bne_noflush", obs, e_zero); step();

    // j ignores rs hazard; hazards during flush are ignored
    drive(1, OP_J, 6'd0, 0, 1, 0); @(negedge clk);
    chk("j_hz_rs", obs, ex(0,0,1,0,0,0,1,PC_JUMP,6'd0,0,0)); step();
    drive(1, OP_RTYPE, FN_ADD, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("j_flush", obs, e_flush); step();
    end
    @(negedge clk); chk("hz_after_flush", obs, e_bub); step();
    drive(0, OP_NOP, 6'd0, 0, 0, 0);
    step(); step();
    @(negedge clk); chk("stall_done", obs, e_zero); step();

    // Hazard outranks illegal, then illegal halts
    drive(1, 6'b010101, 6'd0, 0, 1, 0); @(negedge clk);
    chk("ill_hz", obs, e_bub); step();
    drive(1, 6'b010101, 6'd0, 0, 0, 0);
    step(); step();
    @(negedge clk); chk("ill_run", obs, e_zero); step();
    drive(1, OP_RTYPE, FN_ADD, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); chk("halt", obs, e_halt); step();
    end
    rst = 1'b1; @(negedge clk);
    chk("halt_rst", obs, e_rst); step();
    rst = 1'b0;
    drive(0, OP_NOP, 6'd0, 0, 0, 0); @(negedge clk);
    chk("after_rst", obs, e_zero); step();

    // Reset in the middle of a stall
    drive(1, OP_SW, 6'd0, 0, 0, 1); @(negedge clk);
    chk("sw_hz2", obs, e_bub); step();
    drive(1, OP_SW, 6'd0, 0, 0, 0); @(negedge clk);
    chk("in_stall", obs, e_bub);
    rst = 1'b1; #1;
    chk("rst_mid_stall", obs, e_rst);
    step();
    rst = 1'b0;
    drive(0, OP_NOP, 6'd0, 0, 0, 0); @(negedge clk);
    chk("stall_aborted", obs, e_zero); step();

    // Unknown R-type funct is illegal
    drive(1, OP_RTYPE, 6'b111111, 0, 0, 0); @(negedge clk);
    chk("bad_funct", obs, e_zero); step();
    @(negedge clk); chk("bad_funct_halt", obs, e_halt); step();

    // Reduced-ISA instance: bne and logic functs are illegal
    rst2 = 1'b0;
    drive2(1, OP_RTYPE, FN_ADD, 0); @(negedge clk);
    chk("nb_add", obs2, ex(1,0,0,0,1,0,1,PC_SEQ,FN_ADD,0,0)); step();
    drive2(1, OP_BNE, 6'd0, 0); @(negedge clk);
    chk("nb_bne", obs2, e_zero); step();
    @(negedge clk); chk("nb_bne_halt", obs2, e_halt); step();
    rst2 = 1'b1; @(negedge clk);
    chk("nb_rst", obs2, e_rst); step();
    rst2 = 1'b0;
    drive2(1, OP_RTYPE, FN_OR, 0); @(negedge clk);
    chk("nb_or", obs2, e_zero); step();
    @(negedge clk); chk("nb_or_halt", obs2, e_halt); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
